// File: rtl/ddr3_wr_pkg.sv
// Shared types and Avalon constants for the DDR3 frame writer.
package ddr3_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned AVL_DATA_W = 128;
  localparam int unsigned AVL_ADDR_W = 26;
  localparam int unsigned AVL_BE_W   = AVL_DATA_W / 8;
  localparam logic [AVL_BE_W-1:0] AVL_BE_ALL = '1;

  // Number of 128-bit words in one frame.
  function automatic int unsigned frame_words(input int unsigned width, input int unsigned height,
                                              input int unsigned bpp);
    return (width * height * bpp) / AVL_BE_W;
  endfunction

endpackage

// File: rtl/ddr3_wr_buf_flags.sv
// Ping-pong buffer bookkeeping: two full flags and the buffer currently being written.
module ddr3_wr_buf_flags (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_set,
  input  logic i_release0,
  input  logic i_release1,
  output logic o_full0,
  output logic o_full1,
  output logic o_wr_sel
);

  logic r_full0;
  logic r_full1;
  logic r_wr_sel;

  // A completing frame takes priority over a release of the same buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full0  <= 1'b0;
      r_full1  <= 1'b0;
      r_wr_sel <= 1'b0;
    end else begin
      if (i_set && !r_wr_sel) begin
        r_full0 <= 1'b1;
      end else if (i_release0) begin
        r_full0 <= 1'b0;
      end
      if (i_set && r_wr_sel) begin
        r_full1 <= 1'b1;
      end else if (i_release1) begin
        r_full1 <= 1'b0;
      end
      if (i_set) begin
        r_wr_sel <= ~r_wr_sel;
      end
    end
  end

  assign o_full0  = r_full0;
  assign o_full1  = r_full1;
  assign o_wr_sel = r_wr_sel;

endmodule

// File: rtl/write_to_ddr3.sv
// Frame writer: drains a show-ahead FIFO into ping-pong DDR3 buffers with fixed Avalon bursts.
// Optional DDR3_WR_FRAME_COUNT_EN adds frame_count and stall_count outputs.
module write_to_ddr3
  import ddr3_wr_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH     = 1280,
  parameter int unsigned IMAGE_HEIGHT    = 1024,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned BURST_LEN       = 4
) (
  input  logic                  ddr3_clk,
  input  logic                  reset,
  input  logic                  src_fifo_empty,
  input  logic [AVL_DATA_W-1:0] src_fifo_rd_data,
  output logic                  src_fifo_rd,
  input  logic [AVL_ADDR_W-1:0] ddr3_buffer0_offset,
  input  logic [AVL_ADDR_W-1:0] ddr3_buffer1_offset,
  input  logic                  release_buffer0,
  input  logic                  release_buffer1,
  output logic                  ddr3_wr_buffer0_full,
  output logic                  ddr3_wr_buffer1_full,
  output logic                  frame_done,
  input  logic                  ddr3_avl_ready,
  output logic                  ddr3_avl_burstbegin,
  output logic [2:0]            ddr3_avl_size,
  output logic                  ddr3_avl_write_req,
  output logic [AVL_ADDR_W-1:0] ddr3_avl_addr,
  output logic [AVL_DATA_W-1:0] ddr3_avl_wdata,
  output logic [AVL_BE_W-1:0]   ddr3_avl_be
`ifdef DDR3_WR_FRAME_COUNT_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           stall_count
`endif
);

  localparam int unsigned FRAME_WORDS = frame_words(IMAGE_WIDTH, IMAGE_HEIGHT, BYTES_PER_PIXEL);
  localparam int unsigned WCNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);
  localparam logic [2:0]        LAST_BEAT = 3'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 7) begin : g_bad_burst_len
    $error("write_to_ddr3: BURST_LEN must be 1..7");
  end else if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame_words
    $error("write_to_ddr3: FRAME_WORDS must be a multiple of BURST_LEN");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [AVL_ADDR_W-1:0] r_base_addr;
  logic [WCNT_W-1:0]     r_word_cnt;
  logic [2:0]            r_beat_cnt;
  logic [WCNT_W-1:0]     w_burst_start;
  logic                  w_full0;
  logic                  w_full1;
  logic                  w_wr_sel;
  logic                  w_sel_full;
  logic                  w_start;
  logic                  w_req;
  logic                  w_beat;
  logic                  w_last;

  ddr3_wr_buf_flags u_buf_flags (
    .i_clk      (ddr3_clk),
    .i_reset    (reset),
    .i_set      (r_state == DONE),
    .i_release0 (release_buffer0),
    .i_release1 (release_buffer1),
    .o_full0    (w_full0),
    .o_full1    (w_full1),
    .o_wr_sel   (w_wr_sel)
  );

  assign w_sel_full = w_wr_sel ? w_full1 : w_full0;
  assign w_start    = (r_state == IDLE) && !w_sel_full;
  assign w_req      = (r_state == BURST) && !src_fifo_empty;
  assign w_beat     = w_req && ddr3_avl_ready;
  assign w_last     = w_beat && (r_beat_cnt == LAST_BEAT) && (r_word_cnt == LAST_WORD);
  // Word count minus beats already sent recovers the burst start without an extra register.
  assign w_burst_start = r_word_cnt - WCNT_W'(r_beat_cnt);

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (!w_sel_full) w_state_next = BURST;
      BURST:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      r_base_addr <= '0;
      r_word_cnt  <= '0;
      r_beat_cnt  <= '0;
    end else if (w_start) begin
      r_base_addr <= w_wr_sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
      r_word_cnt  <= '0;
      r_beat_cnt  <= '0;
    end else if (w_beat) begin
      r_word_cnt <= (r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + 1'b1;
      r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
    end
  end

  always_comb begin
    ddr3_avl_write_req  = w_req;
    ddr3_avl_burstbegin = w_req && (r_beat_cnt == 3'd0);
    src_fifo_rd         = w_beat;
    frame_done          = (r_state == DONE);
    ddr3_avl_addr       = r_base_addr + AVL_ADDR_W'(w_burst_start);
  end

  assign ddr3_avl_wdata       = src_fifo_rd_data;
  assign ddr3_avl_size        = 3'(BURST_LEN);
  assign ddr3_avl_be          = AVL_BE_ALL;
  assign ddr3_wr_buffer0_full = w_full0;
  assign ddr3_wr_buffer1_full = w_full1;

`ifdef DDR3_WR_FRAME_COUNT_EN
  logic [15:0] r_frame_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge ddr3_clk) begin
    if (reset) begin
      r_frame_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state == DONE) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_req && !ddr3_avl_ready && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign frame_count = r_frame_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_write_to_ddr3.sv
// Bench for write_to_ddr3 on a reduced 8-word frame: table-driven frame scenarios, random traffic
// and a mid-burst reset, all checked against a frame-level reference model.
module tb_write_to_ddr3;

  localparam int FW = 8;
  localparam int BL = 4;
  localparam logic [25:0] OFF0 = 26'h0000100;
  localparam logic [25:0] OFF1 = 26'h0002000;

  logic         ddr3_clk = 1'b0;
  logic         reset = 1'b1;
  logic         src_fifo_empty = 1'b1;
  logic [127:0] src_fifo_rd_data = '0;
  logic         src_fifo_rd;
  logic         release_buffer0 = 1'b0;
  logic         release_buffer1 = 1'b0;
  logic         ddr3_wr_buffer0_full;
  logic         ddr3_wr_buffer1_full;
  logic         frame_done;
  logic         ddr3_avl_ready = 1'b1;
  logic         ddr3_avl_burstbegin;
  logic [2:0]   ddr3_avl_size;
  logic         ddr3_avl_write_req;
  logic [25:0]  ddr3_avl_addr;
  logic [127:0] ddr3_avl_wdata;
  logic [15:0]  ddr3_avl_be;
`ifdef DDR3_WR_FRAME_COUNT_EN
  logic [15:0]  frame_count;
  logic [15:0]  stall_count;
`endif

  always #5 ddr3_clk = ~ddr3_clk;

  write_to_ddr3 #(
    .IMAGE_WIDTH     (8),
    .IMAGE_HEIGHT    (4),
    .BYTES_PER_PIXEL (4),
    .BURST_LEN       (BL)
  ) dut (
    .ddr3_clk             (ddr3_clk),
    .reset                (reset),
    .src_fifo_empty       (src_fifo_empty),
    .src_fifo_rd_data     (src_fifo_rd_data),
    .src_fifo_rd          (src_fifo_rd),
    .ddr3_buffer0_offset  (OFF0),
    .ddr3_buffer1_offset  (OFF1),
    .release_buffer0      (release_buffer0),
    .release_buffer1      (release_buffer1),
    .ddr3_wr_buffer0_full (ddr3_wr_buffer0_full),
    .ddr3_wr_buffer1_full (ddr3_wr_buffer1_full),
    .frame_done           (frame_done),
    .ddr3_avl_ready       (ddr3_avl_ready),
    .ddr3_avl_burstbegin  (ddr3_avl_burstbegin),
    .ddr3_avl_size        (ddr3_avl_size),
    .ddr3_avl_write_req   (ddr3_avl_write_req),
    .ddr3_avl_addr        (ddr3_avl_addr),
    .ddr3_avl_wdata       (ddr3_avl_wdata),
    .ddr3_avl_be          (ddr3_avl_be)
`ifdef DDR3_WR_FRAME_COUNT_EN
    ,
    .frame_count          (frame_count),
    .stall_count          (stall_count)
`endif
  );

  typedef struct {
    int          rel_before;   // bit0: release buffer0, bit1: release buffer1
    bit          idle_check;
    int          gap_at;
    int          gap_len;
    int          rdy_at;
    int          rdy_len;
    bit          rel0_on_done;
    logic [25:0] exp_first;
    int          exp_pops;
    int          exp_req_low;
    int          exp_stall;
    bit          exp_full0;
    bit          exp_full1;
  } scen_t;

  int checks = 0;
  int errors = 0;

  logic [127:0] q[$];
  int k = 0;
  bit m_full[2];
  int m_sel = 0;
  bit pending = 0;
  int m_frames = 0;
  int m_stall = 0;
  bit drv_empty = 1'b1;
  bit skip = 1'b1;

  logic        s_req, s_bb, s_rd, s_done, s_full0, s_full1;
  logic [25:0] s_addr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_sel = 0;
    pending = 1'b0;
    m_frames = 0;
    m_stall = 0;
  endtask

  // One clock: drive FIFO view, sample at negedge, check, then update model after posedge.
  task automatic tick();
    bit xfer;
    bit rel[2];
    bit setb[2];
    int exp_addr;
    src_fifo_empty   = drv_empty || (q.size() == 0);
    src_fifo_rd_data = (q.size() != 0) ? q[0] : '0;
    @(negedge ddr3_clk);
    s_req   = ddr3_avl_write_req;
    s_bb    = ddr3_avl_burstbegin;
    s_rd    = src_fifo_rd;
    s_done  = frame_done;
    s_full0 = ddr3_wr_buffer0_full;
    s_full1 = ddr3_wr_buffer1_full;
    s_addr  = ddr3_avl_addr;
    xfer    = (s_req === 1'b1) && ddr3_avl_ready;
    if (!skip) begin
      chk("src_fifo_rd", int'(s_rd), int'(xfer));
      chk("frame_done", int'(s_done), int'(pending));
      chk("buffer0_full", int'(s_full0), int'(m_full[0]));
      chk("buffer1_full", int'(s_full1), int'(m_full[1]));
      if (src_fifo_empty) chk("req_while_empty", int'(s_req), 0);
      if (k > 0) chk("req_mid_frame", int'(s_req), int'(!src_fifo_empty));
      if (pending || (m_full[0] && m_full[1])) chk("req_not_writing", int'(s_req), 0);
      if (s_req === 1'b1) begin
        exp_addr = int'(m_sel != 0 ? OFF1 : OFF0) + (k / BL) * BL;
        chk_w("wdata", ddr3_avl_wdata, q[0]);
        chk("addr", int'(s_addr), exp_addr);
        chk("burstbegin", int'(s_bb), int'((k % BL) == 0));
      end
      if (k > 0 && !src_fifo_empty && !ddr3_avl_ready) m_stall++;
    end
    rel[0] = release_buffer0;
    rel[1] = release_buffer1;
    @(posedge ddr3_clk);
    #1;
    if (!skip) begin
      setb[0] = pending && (m_sel == 0);
      setb[1] = pending && (m_sel == 1);
      for (int b = 0; b < 2; b++) m_full[b] = setb[b] ? 1'b1 : (rel[b] ? 1'b0 : m_full[b]);
      if (pending) begin
        m_sel ^= 1;
        m_frames++;
        pending = 1'b0;
      end
      if (xfer) begin
        k++;
        if (k == FW) begin
          k = 0;
          pending = 1'b1;
        end
      end
    end
    if (xfer) void'(q.pop_front());
    while (q.size() < 4) q.push_back({$urandom, $urandom, $urandom, $urandom});
    release_buffer0 = 1'b0;
    release_buffer1 = 1'b0;
  endtask

  task automatic run_frame(input scen_t s);
    int start, pops, req_low, stall, gap_left, rdy_left, kb;
    bit gap_used, rdy_used, got_first;
    logic [25:0] first;
    start = m_frames;
    pops = 0; req_low = 0; stall = 0; gap_left = 0; rdy_left = 0;
    gap_used = 1'b0; rdy_used = 1'b0; got_first = 1'b0; first = '0;
    for (int t = 0; t < 200 && m_frames == start; t++) begin
      kb = k;
      if (s.gap_len > 0 && !gap_used && k == s.gap_at) begin
        gap_left = s.gap_len;
        gap_used = 1'b1;
      end
      if (s.rdy_len > 0 && !rdy_used && k == s.rdy_at) begin
        rdy_left = s.rdy_len;
        rdy_used = 1'b1;
      end
      drv_empty      = (gap_left > 0);
      ddr3_avl_ready = !(rdy_left > 0);
      if (gap_left > 0) gap_left--;
      if (rdy_left > 0) rdy_left--;
      release_buffer0 = s.rel0_on_done && pending;
      tick();
      if (s_rd === 1'b1) pops++;
      if (kb > 0 && s_req !== 1'b1) req_low++;
      if (s_req === 1'b1 && !ddr3_avl_ready) stall++;
      if (s_req === 1'b1 && !got_first) begin
        got_first = 1'b1;
        first = s_addr;
      end
    end
    chk("frame_completed", m_frames - start, 1);
    chk("frame_pops", pops, s.exp_pops);
    chk("frame_req_low", req_low, s.exp_req_low);
    chk("frame_stall", stall, s.exp_stall);
    chk("frame_first_addr", int'(first), int'(s.exp_first));
    drv_empty = 1'b1;
    ddr3_avl_ready = 1'b1;
    repeat (2) tick();
    chk("after_full0", int'(s_full0), int'(s.exp_full0));
    chk("after_full1", int'(s_full1), int'(s.exp_full1));
  endtask

  task automatic chk_counters();
`ifdef DDR3_WR_FRAME_COUNT_EN
    chk("frame_count", int'(frame_count), m_frames % 65536);
    chk("stall_count", int'(stall_count), (m_stall > 65535) ? 65535 : m_stall);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t tbl[5];
    int start;
    int ipops, ireq;
    //          rel idl gap    rdy    r0d first exp: pops low stall f0 f1
    tbl[0] = '{0, 0, -1, 0, -1, 0, 0, OFF0, 8, 0, 0, 1, 0};
    tbl[1] = '{0, 0,  2, 5, -1, 0, 0, OFF1, 8, 5, 0, 1, 1};
    tbl[2] = '{1, 1, -1, 0,  1, 3, 0, OFF0, 8, 0, 3, 1, 1};
    tbl[3] = '{2, 0, -1, 0, -1, 0, 0, OFF1, 8, 0, 0, 1, 1};
    tbl[4] = '{1, 0, -1, 0, -1, 0, 1, OFF0, 8, 0, 0, 1, 1};

    while (q.size() < 4) q.push_back({$urandom, $urandom, $urandom, $urandom});
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    skip = 1'b0;
    tick();
    chk("rst_write_req", int'(s_req), 0);
    chk("rst_burstbegin", int'(s_bb), 0);
    chk("rst_src_fifo_rd", int'(s_rd), 0);
    chk("rst_frame_done", int'(s_done), 0);
    chk("rst_full0", int'(s_full0), 0);
    chk("rst_full1", int'(s_full1), 0);
    chk("avl_size", int'(ddr3_avl_size), BL);
    chk("avl_be", int'(ddr3_avl_be), 'hFFFF);
    chk_counters();

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].idle_check) begin
        ipops = 0;
        ireq = 0;
        drv_empty = 1'b0;
        repeat (8) begin
          tick();
          if (s_rd === 1'b1) ipops++;
          if (s_req === 1'b1) ireq++;
        end
        chk("both_full_pops", ipops, 0);
        chk("both_full_req", ireq, 0);
      end
      drv_empty = 1'b1;
      release_buffer0 = tbl[i].rel_before[0];
      release_buffer1 = tbl[i].rel_before[1];
      tick();
      run_frame(tbl[i]);
    end
    chk_counters();

    // Random traffic; ready only drops mid-frame so every stall is attributable.
    start = m_frames;
    for (int t = 0; t < 3000 && m_frames < start + 3; t++) begin
      ddr3_avl_ready  = (k == 0) ? 1'b1 : ($urandom_range(3) != 0);
      drv_empty       = ($urandom_range(3) == 0);
      release_buffer0 = ($urandom_range(7) == 0);
      release_buffer1 = ($urandom_range(7) == 0);
      tick();
    end
    chk("random_frames", m_frames - start, 3);
    ddr3_avl_ready = 1'b1;
    chk_counters();

    // Reset on beat 2 of burst 1.
    drv_empty = 1'b1;
    release_buffer0 = 1'b1;
    release_buffer1 = 1'b1;
    tick();
    drv_empty = 1'b0;
    for (int t = 0; t < 100 && k != 6; t++) tick();
    chk("reached_beat6", k, 6);
    reset = 1'b1;
    drv_empty = 1'b1;
    skip = 1'b1;
    tick();
    reset = 1'b0;
    skip = 1'b0;
    model_reset();
    tick();
    chk("midrst_write_req", int'(s_req), 0);
    chk("midrst_burstbegin", int'(s_bb), 0);
    chk("midrst_src_fifo_rd", int'(s_rd), 0);
    chk("midrst_frame_done", int'(s_done), 0);
    chk("midrst_full0", int'(s_full0), 0);
    chk("midrst_full1", int'(s_full1), 0);
    chk_counters();
    run_frame(tbl[0]);
    chk_counters();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
